grf_wb_arbiter: RTL
===================

// Module: grf_wb_arbiter
// PURPOSE
//  Shares the single GRF write port between the pipeline W stage and the
//  long-latency mult/div unit (MDU) result path. Buffers MDU results in a
//  small FIFO and prevents MDU starvation by holding the W stage.
//  Keeps a busy scoreboard of GRF registers with an MDU write outstanding,
//  so decode can stall on them. Sits between W stage/MDU and the GRF.
// PARAMETERS
//  DEPTH      2  MDU result FIFO entries (power of 2, >=2)
//  STARVE_MAX 4  max consecutive cycles pipeline may win while FIFO non-empty
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  p_we       in   1   W-stage write request (cannot be back-pressured, only held)
//  p_a3       in   5   W-stage destination register
//  p_wd       in   32  W-stage write data
//  p_pc       in   32  W-stage instruction PC
//  m_valid    in   1   MDU result valid
//  m_ready    out  1   FIFO can accept (= !full)
//  m_a3       in   5   MDU destination register
//  m_wd       in   32  MDU result data
//  m_pc       in   32  MDU instruction PC
//  iss_valid  in   1   MDU op issued this cycle; marks iss_a3 busy
//  iss_a3     in   5   destination of issued MDU op
//  rd_a1      in   5   decode source 1 lookup
//  rd_a2      in   5   decode source 2 lookup
//  busy1      out  1   scoreboard bit for rd_a1 (comb)
//  busy2      out  1   scoreboard bit for rd_a2 (comb)
//  busy3      out  1   scoreboard bit for iss_a3 (comb; decode must not issue if 1)
//  wb_hold    out  1   W stage must hold its instruction this cycle
//  grf_we     out  1   GRF write enable
//  grf_a3     out  5   GRF write address
//  grf_wd     out  32  GRF write data
//  grf_pc     out  32  GRF write PC (for write trace)
// BEHAVIOUR
//  - State: FIFO {a3,wd,pc} x DEPTH, rd/wr pointers + count, starve_cnt, busy[31:1].
//  - Reset: FIFO emptied, starve_cnt=0, busy all 0. While reset=1: m_ready=0,
//    grf_we=0, wb_hold=0, busy1/2/3=0. Reset mid-operation discards queued results.
//  - Arbitration (comb, from registered state + p_we):
//    grant_m = !empty && (!p_we || starve_cnt==STARVE_MAX)
//    grant_p = p_we && !grant_m;  wb_hold = p_we && grant_m.
//  - GRF outputs comb, zero latency: grf_we = grant_p|grant_m; fields muxed from
//    W stage on grant_p, FIFO head on grant_m; fields 0 when grf_we=0.
//  - a3==0 writes forwarded unchanged (GRF ignores them).
//  - FIFO: push when m_valid&&m_ready; pop when grant_m. m_ready from registered
//    count only: full => no push even if popping that cycle. Push into empty FIFO
//    is visible at head the next cycle (1-cycle minimum MDU-to-GRF latency).
//    Pointers wrap modulo DEPTH.
//  - starve_cnt: ->0 if empty or grant_m; else if p_we (pipeline won over
//    non-empty FIFO) -> +1, saturating at STARVE_MAX; else unchanged.
//  - Scoreboard: set busy[iss_a3] on iss_valid && iss_a3!=0; clear busy[grf_a3]
//    on grant_m. Same register set+clear same cycle -> stays 1 (set wins).
//    busy[0] reads 0 always. Issue to busy register is illegal (decode stalls
//    on busy3); behaviour then undefined, bench asserts it never occurs.
//  - Pipeline writes never touch scoreboard.
// TESTING
//  1. p_we=1,p_a3=5,p_wd=0x1234,FIFO empty -> same cycle grf_we=1,grf_a3=5,
//     grf_wd=0x1234, wb_hold=0.
//  2. iss a3=8; next cycle busy(8)=1; m_valid a3=8 wd=0xCAFE -> following cycle
//     grf_we=1,a3=8,wd=0xCAFE; busy(8)=0 cycle after.
//  3. One FIFO entry, p_we held 1: 4 cycles grant_p, 5th cycle grant_m with
//     wb_hold=1, then starve_cnt=0 and pipeline wins again.
//  4. p_we=1 continuously, push 2 MDU results -> m_ready=0; 3rd m_valid not
//     accepted; after starvation pop m_ready=1 next cycle; FIFO order preserved.
//  5. grant_m clears reg 9 while iss_valid a3=9 same cycle -> busy(9) stays 1.
//  6. FIFO holding 2 entries, busy{3,4}=1, reset 1 cycle -> count 0, busy all 0,
//     no grf_we from stale entries; m_ready=1 first cycle after reset drops.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the GRF write port between the W stage and buffered MDU results, with a busy scoreboard.
module grf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_we,
  input  logic [4:0]  p_a3,
  input  logic [31:0] p_wd,
  input  logic [31:0] p_pc,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_a3,
  input  logic [31:0] m_wd,
  input  logic [31:0] m_pc,
  input  logic        iss_valid,
  input  logic [4:0]  iss_a3,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  output logic        busy1,
  output logic        busy2,
  output logic        busy3,
  output logic        wb_hold,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;
  ent_t fifo_q [DEPTH];
  ent_t fifo_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:1] busy_q, busy_d;
  logic [31:0] busy_v, busy_n;
  logic empty, push, grant_m, grant_p;
  ent_t head;
  always_comb begin
    empty = cnt_q == '0;
    head = fifo_q[rd_q];
    m_ready = !reset && cnt_q != FULL;
    grant_m = !reset && !empty && (!p_we || starve_q == SMAX);
    grant_p = !reset && p_we && !grant_m;
    wb_hold = p_we && grant_m;
    push = m_valid && m_ready;
    grf_we = grant_p || grant_m;
    grf_a3 = grant_m ? head.a3 : grant_p ? p_a3 : '0;
    grf_wd = grant_m ? head.wd : grant_p ? p_wd : '0;
    grf_pc = grant_m ? head.pc : grant_p ? p_pc : '0;
    busy_v = reset ? '0 : {busy_q, 1'b0};
    busy1 = busy_v[rd_a1];
    busy2 = busy_v[rd_a2];
    busy3 = busy_v[iss_a3];
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = {m_a3, m_wd, m_pc};
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(grant_m);
    cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(grant_m);
    starve_d = (empty || grant_m) ? '0 : (p_we && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
    // set is applied after clear so a same-cycle reissue keeps the register busy
    busy_n = {busy_q, 1'b0};
    if (grant_m) busy_n[head.a3] = 1'b0;
    if (iss_valid) busy_n[iss_a3] = 1'b1;
    busy_d = busy_n[31:1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      starve_q <= '0;
      busy_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      starve_q <= starve_d;
      busy_q <= busy_d;
    end
  end
  always_ff @(posedge clk) fifo_q <= fifo_d;
endmodule
